// File: rtl/pixel_pkg.sv
// ============================================================================
// pixel_pkg : shared screen geometry, pixel entry type and address helper
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package pixel_pkg;

   localparam int WIDTH  = 160;
   localparam int HEIGHT = 120;
   localparam int XW     = 8;
   localparam int YW     = 7;
   localparam int CW     = 3;
   localparam int AW     = 15;
   localparam int PIX_W  = YW + XW + CW + 1;

   typedef struct packed {
      logic [YW-1:0] row;
      logic [XW-1:0] x;
      logic [CW-1:0] colour;
      logic          last;
   } pixel_t;

   // row*160 + x without a multiplier: 160 = 128 + 32
   function automatic logic [AW-1:0] pix_addr(input logic [YW-1:0] row,
                                              input logic [XW-1:0] col);
      logic [AW-1:0] r;
      r = AW'(row);
      return (r << 7) + (r << 5) + AW'(col);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_fifo.sv
// ============================================================================
// pixel_fifo : synchronous FIFO of DEPTH entries (DEPTH a power of two, >= 2)
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module pixel_fifo
   import pixel_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = PIX_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DW-1:0]              wdata,
   output logic [DW-1:0]              rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DW-1:0]    mem_q [DEPTH];
   logic [DW-1:0]    mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/pixel_sink.sv
// ============================================================================
// pixel_sink : buffers pixel plots, applies vertical scroll, writes frame buffer
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module pixel_sink
   import pixel_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic          Clock,
   input  logic          Resetn,
   input  logic [XW-1:0] x,
   input  logic [YW-1:0] y,
   input  logic [CW-1:0] colour,
   input  logic          plot,
   input  logic [YW-1:0] scroll,
   input  logic          scroll_load,
   output logic [AW-1:0] mem_addr,
   output logic [CW-1:0] mem_data,
   output logic          mem_we,
   input  logic          mem_ready,
   output logic          busy,
   output logic          frame_done,
   output logic          overflow,
   output logic          range_err
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [YW-1:0]    offset_q, offset_d;
   logic [AW-1:0]    mem_addr_q, mem_addr_d;
   logic [CW-1:0]    mem_data_q, mem_data_d;
   logic             mem_we_q, mem_we_d;
   logic             last_q, last_d;
   logic             frame_done_q, frame_done_d;
   logic             overflow_q, overflow_d;
   logic             range_err_q, range_err_d;

   logic             in_range, room, push, pop;
   logic             fifo_full, fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic [7:0]       row_sum;
   logic [YW-1:0]    row_eff;
   pixel_t           in_pix, head_pix;
   logic [PIX_W-1:0] head_bits;

   always_comb begin
      in_range = (x < XW'(WIDTH)) && (y < YW'(HEIGHT));
      // Both operands are below 120, so one subtract folds the sum back on screen
      row_sum  = {1'b0, y} + {1'b0, offset_q};
      row_eff  = (row_sum >= 8'(HEIGHT)) ? YW'(row_sum - 8'(HEIGHT)) : row_sum[YW-1:0];

      in_pix.row    = row_eff;
      in_pix.x      = x;
      in_pix.colour = colour;
      in_pix.last   = (x == XW'(WIDTH - 1)) && (y == YW'(HEIGHT - 1));

      head_pix = pixel_t'(head_bits);
      pop      = !fifo_empty && (!mem_we_q || mem_ready);
      room     = !fifo_full || pop;
      push     = plot && in_range && room;
   end

   always_comb begin
      offset_d     = offset_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      mem_we_d     = mem_we_q;
      last_d       = last_q;

      if (scroll_load) begin
         offset_d = (scroll >= YW'(HEIGHT)) ? scroll - YW'(HEIGHT) : scroll;
      end

      if (pop) begin
         mem_addr_d = pix_addr(head_pix.row, head_pix.x);
         mem_data_d = head_pix.colour;
         mem_we_d   = 1'b1;
         last_d     = head_pix.last;
      end else if (mem_we_q && mem_ready) begin
         mem_we_d = 1'b0;
      end

      frame_done_d = mem_we_q && mem_ready && last_q;
      overflow_d   = overflow_q  | (plot && in_range && !room);
      range_err_d  = range_err_q | (plot && !in_range);
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         offset_q     <= '0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         mem_we_q     <= 1'b0;
         last_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         range_err_q  <= 1'b0;
      end else begin
         offset_q     <= offset_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         mem_we_q     <= mem_we_d;
         last_q       <= last_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
         range_err_q  <= range_err_d;
      end
   end

   pixel_fifo #(
      .DEPTH (DEPTH),
      .DW    (PIX_W)
   ) u_fifo (
      .clk   (Clock),
      .rst_n (Resetn),
      .push  (push),
      .pop   (pop),
      .wdata (in_pix),
      .rdata (head_bits),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign mem_addr   = mem_addr_q;
   assign mem_data   = mem_data_q;
   assign mem_we     = mem_we_q;
   assign busy       = (fifo_count != '0) || mem_we_q;
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;
   assign range_err  = range_err_q;

endmodule

`default_nettype wire

// File: doc/pixel_sink.md
# pixel_sink

Receiving end of the pixel-plot stream (x, y, colour, plot) that the background and object drawers produce. Buffers incoming plots in a small FIFO and applies a vertical scroll offset. Converts each pixel to a linear 160x120 frame-buffer address and writes it to the frame-buffer memory port with a we/ready handshake. Sits between the drawing logic and the frame-buffer memory, and decouples plot bursts from memory stalls.

## Interface
- WIDTH, 160, screen columns
- HEIGHT, 120, screen rows
- XW, 8, x coordinate width
- YW, 7, y coordinate width
- CW, 3, colour width (1 bit per channel)
- AW, 15, frame-buffer address width
- DEPTH, 4, FIFO entries (power of two)

Ports:
- Clock  in  1  system clock; single clock domain
- Resetn  in  1  asynchronous, active-low reset
- x  in  XW  pixel column
- y  in  YW  pixel row
- colour  in  CW  pixel colour
- plot  in  1  pixel valid, sampled every rising edge
- scroll  in  YW  new row offset
- scroll_load  in  1  latch scroll into offset register
- mem_addr  out  AW  write address
- mem_data  out  CW  write colour
- mem_we  out  1  write request
- mem_ready  in  1  memory accepts the write on an edge where mem_we=1
- busy  out  1  FIFO non-empty or mem_we=1
- frame_done  out  1  one-cycle pulse
- overflow  out  1  sticky; a plot was dropped because the FIFO was full
- range_err  out  1  sticky; a plot had x>=WIDTH or y>=HEIGHT

## Operation
- Reset values: mem_addr=0, mem_data=0, mem_we=0, busy=0, frame_done=0, overflow=0, range_err=0. The offset register and FIFO are cleared.
- Offset: when scroll_load=1 at an edge, offset<=scroll. Values of 120 and above are reduced mod 120.
- Enqueue on a plot=1 edge:
  - Out-of-range coordinates: the plot is discarded and range_err is set. FIFO is unchanged.
  - Otherwise, if there is room, push {row_eff, x, colour, last}.
    - row_eff = (y+offset) mod 120, computed with an 8-bit sum and one conditional subtract of 120.
    - last = (x==159 && y==119), using the source coordinates.
    - The offset used is the value before any same-edge scroll_load.
  - Room exists when count<DEPTH, or when a pop occurs on the same edge.
  - No room: the plot is discarded and overflow is set.
- Output register (mem_*): loads from the FIFO head when the FIFO is non-empty and (mem_we=0 or mem_ready=1).
  - Loads: mem_addr=row_eff*160+x, computed as (row<<7)+(row<<5)+x. mem_data=colour. mem_we=1.
  - Write accepted with the FIFO empty: mem_we drops to 0 on that edge.
  - mem_addr and mem_data stay stable while mem_we=1 and mem_ready=0.
- frame_done: high for exactly one cycle after the edge where an entry with last=1 is accepted (mem_we && mem_ready).
- Sticky flags clear only on reset.
- Reset mid-operation: the in-flight write and all queued entries are lost, and all outputs take their reset values immediately (asynchronous).

## Timing
- Latency: a plot sampled at edge N, with the FIFO empty and mem_we=0, gives mem_we=1 with its address after edge N+1.
- Throughput: one pixel per clock while mem_ready stays 1.
- Capacity while stalled: DEPTH+1 pixels (FIFO plus the output register) before drops.
- Simultaneous push and pop when full: the push is accepted and count is unchanged.
- A scroll_load affects only plots sampled on later edges.
- Pointers wrap modulo DEPTH.

## Structure
- Shared package pixel_pkg: WIDTH, HEIGHT, XW, YW, CW, AW constants; a pixel-entry struct {row, x, colour, last}; and an address function row*160+x. The drawing blocks will reuse these.
- One sub-module, pixel_fifo: a synchronous FIFO of DEPTH entries with push, pop, full, empty and count.
- The top contains the offset register, range check, output register and flags.

## Test plan
- Reset, offset 0, mem_ready=1; plot x=5,y=3,colour=3'b101 → after next edge mem_addr=485, mem_data=5, mem_we=1, and mem_we=0 one edge later.
- scroll=118 with scroll_load, then plot x=0,y=3 → mem_addr=160.
- mem_ready=0, six consecutive plots → five are held (1 output + 4 FIFO), overflow=1 after the sixth. Then release mem_ready → exactly five writes in order.
- Plot x=160,y=0 → range_err=1, no mem_we. Plot x=0,y=120 → same.
- Full-frame raster (19200 plots, mem_ready=1) → 19200 writes; the final mem_addr=19199; one frame_done pulse the cycle after the last acceptance.
- Resetn low while mem_we=1 with the FIFO holding 3 entries → outputs zero immediately; after release, no stale writes appear.
